// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor slice plus a borrow flop, LSB first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [CW-1:0]     cnt_reg;
    logic [WIDTH-1:0]  sa_reg;
    logic [WIDTH-1:0]  sb_reg;
    logic [WIDTH-1:0]  sd_reg;
    logic              bor_reg;
`ifdef SERIAL_SUB_OVF_EN
    logic              am_reg;
    logic              bm_reg;
`endif

    // Full-subtractor slice built from two half-subtractors and an OR.
    logic x, y, hd, hb1, hb2, d_bit, bor_next;
    assign x        = sa_reg[0];
    assign y        = sb_reg[0];
    assign hd       = x ^ y;
    assign hb1      = ~x & y;
    assign hb2      = ~hd & bor_reg;
    assign d_bit    = hd ^ bor_reg;
    assign bor_next = hb1 | hb2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            sa_reg     <= '0;
            sb_reg     <= '0;
            sd_reg     <= '0;
            bor_reg    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            am_reg     <= 1'b0;
            bm_reg     <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sa_reg    <= a;
                        sb_reg    <= b;
                        bor_reg   <= 1'b0;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
`ifdef SERIAL_SUB_OVF_EN
                        am_reg    <= a[WIDTH-1];
                        bm_reg    <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    sa_reg  <= sa_reg >> 1;
                    sb_reg  <= sb_reg >> 1;
                    sd_reg  <= {d_bit, sd_reg[WIDTH-1:1]};
                    bor_reg <= bor_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    // The result registers take the final bit directly so done lands in DONE.
                    if (cnt_reg == LAST) begin
                        state_reg  <= DONE;
                        done       <= 1'b1;
                        diff       <= {d_bit, sd_reg[WIDTH-1:1]};
                        borrow_out <= bor_next;
`ifdef SERIAL_SUB_OVF_EN
                        ovf        <= (am_reg != bm_reg) && (d_bit != am_reg);
`endif
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed and swept checks of serial_sub at WIDTH=8 and WIDTH=2.
// Overflow checks are compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start2;
    logic [7:0] a8, b8, diff8;
    logic [1:0] a2, b2, diff2;
    logic       busy8, done8, bo8;
    logic       busy2, done2, bo2;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8, ovf2;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8),
`ifdef SERIAL_SUB_OVF_EN
        .ovf(ovf8),
`endif
        .borrow_out(bo8)
    );

    serial_sub #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .diff(diff2),
`ifdef SERIAL_SUB_OVF_EN
        .ovf(ovf2),
`endif
        .borrow_out(bo2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start8 = 1'b0; start2 = 1'b0;
        a8 = '0; b8 = '0; a2 = '0; b2 = '0;
        repeat (3) tick();
        tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy8); end
        tests++; if (done8 !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done8); end
        tests++; if (diff8 !== 8'h00) begin fails++; $display("FAIL reset_diff got %h want 00", diff8); end
        tests++; if (bo8 !== 1'b0) begin fails++; $display("FAIL reset_borrow got %b want 0", bo8); end
`ifdef SERIAL_SUB_OVF_EN
        tests++; if (ovf8 !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", ovf8); end
`endif
        $display("[TB] reset: busy=%b done=%b diff=%h borrow=%b", busy8, done8, diff8, bo8);
        rst_n = 1'b1;
        tick();
    endtask

    // One operation on the WIDTH=8 unit, checking latency, busy length and result.
    task automatic do_op8(input string nm, input logic [7:0] ai, input logic [7:0] bi,
                          input logic [7:0] ed, input logic eb);
        int  lat, nbusy;
        bit  seen;
        a8 = ai; b8 = bi; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        nbusy = busy8 ? 1 : 0;
        lat = 0; seen = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            tick();
            if (busy8) nbusy++;
            if (done8) begin seen = 1; lat = k; end
        end
        tests++; if (!seen || lat != 8) begin fails++; $display("FAIL %s_latency got %0d want 8", nm, lat); end
        tests++; if (diff8 !== ed) begin fails++; $display("FAIL %s_diff got %h want %h", nm, diff8, ed); end
        tests++; if (bo8 !== eb) begin fails++; $display("FAIL %s_borrow got %b want %b", nm, bo8, eb); end
`ifdef SERIAL_SUB_OVF_EN
        begin
            logic eo;
            eo = (ai[7] != bi[7]) && (ed[7] != ai[7]);
            tests++; if (ovf8 !== eo) begin fails++; $display("FAIL %s_ovf got %b want %b", nm, ovf8, eo); end
        end
`endif
        $display("[TB] %s: a=%h b=%h diff=%h borrow=%b latency=%0d", nm, ai, bi, diff8, bo8, lat);
        tick();
        tests++; if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            fails++; $display("FAIL %s_end got done=%b busy=%b want 0 0", nm, done8, busy8);
        end
        tests++; if (nbusy != 9) begin fails++; $display("FAIL %s_busy_len got %0d want 9", nm, nbusy); end
    endtask

    task automatic test_basic();
        do_op8("sub_5a_23", 8'h5A, 8'h23, 8'h37, 1'b0);
        do_op8("sub_10_20", 8'h10, 8'h20, 8'hF0, 1'b1);
        do_op8("sub_00_01", 8'h00, 8'h01, 8'hFF, 1'b1);
        do_op8("sub_ff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0);
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        do_op8("ovf_80_01", 8'h80, 8'h01, 8'h7F, 1'b0);
        tests++; if (ovf8 !== 1'b1) begin fails++; $display("FAIL ovf_80_01 got %b want 1", ovf8); end
        do_op8("ovf_7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1);
        tests++; if (ovf8 !== 1'b1) begin fails++; $display("FAIL ovf_7f_ff got %b want 1", ovf8); end
        do_op8("ovf_05_03", 8'h05, 8'h03, 8'h02, 1'b0);
        tests++; if (ovf8 !== 1'b0) begin fails++; $display("FAIL ovf_05_03 got %b want 0", ovf8); end
    endtask
`endif

    task automatic test_ignore_start();
        int         ndone;
        logic [7:0] got;
        ndone = 0; got = 8'h00;
        a8 = 8'h5A; b8 = 8'h23; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        a8 = 8'h00; b8 = 8'h01; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done8) begin ndone++; got = diff8; end
        end
        tests++; if (ndone != 1) begin fails++; $display("FAIL ignore_count got %0d want 1", ndone); end
        tests++; if (got !== 8'h37) begin fails++; $display("FAIL ignore_diff got %h want 37", got); end
        $display("[TB] ignore_start: dones=%0d diff=%h", ndone, got);
    endtask

    task automatic test_reset_mid();
        int ndone;
        ndone = 0;
        a8 = 8'h5A; b8 = 8'h23; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        tests++; if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00) begin
            fails++; $display("FAIL midreset_async got busy=%b done=%b diff=%h want 0 0 00", busy8, done8, diff8);
        end
        repeat (3) begin tick(); if (done8) ndone++; end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin tick(); if (done8) ndone++; end
        tests++; if (ndone != 0) begin fails++; $display("FAIL midreset_nodone got %0d want 0", ndone); end
        $display("[TB] reset_mid: busy=%b diff=%h dones=%0d", busy8, diff8, ndone);
        do_op8("after_reset", 8'h09, 8'h04, 8'h05, 1'b0);
    endtask

    task automatic test_sweep8();
        logic [8:0] r;
        int  last;
        bit  seen;
        int  nerr;
        nerr = 0; last = 0;
        a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            seen = 0;
            for (int k = 0; k < 30 && !seen; k++) begin tick(); if (done8) seen = 1; end
            tests++;
            if (!seen) begin fails++; $display("FAIL sweep8_timeout at op %0d", i); break; end
            r = {1'b0, a8} - {1'b0, b8};
            if ({bo8, diff8} !== r) begin
                fails++; nerr++;
                $display("FAIL sweep8_result op %0d a=%h b=%h got %b_%h want %b_%h", i, a8, b8, bo8, diff8, r[8], r[7:0]);
            end
`ifdef SERIAL_SUB_OVF_EN
            tests++;
            if (ovf8 !== ((a8[7] != b8[7]) && (r[7] != a8[7]))) begin
                fails++; nerr++; $display("FAIL sweep8_ovf op %0d got %b", i, ovf8);
            end
`endif
            if (i > 0) begin
                tests++;
                if (cyc - last != 10) begin fails++; nerr++; $display("FAIL sweep8_spacing got %0d want 10", cyc - last); end
            end
            last = cyc;
            if (i == 999) start8 = 1'b0;
            else begin a8 = 8'($urandom); b8 = 8'($urandom); end
        end
        start8 = 1'b0;
        repeat (12) tick();
        $display("[TB] sweep WIDTH=8: 1000 ops, %0d errors", nerr);
    endtask

    task automatic test_sweep2();
        logic [2:0] r;
        int  last;
        bit  seen;
        int  nerr;
        nerr = 0; last = 0;
        a2 = 2'($urandom); b2 = 2'($urandom); start2 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            seen = 0;
            for (int k = 0; k < 30 && !seen; k++) begin tick(); if (done2) seen = 1; end
            tests++;
            if (!seen) begin fails++; $display("FAIL sweep2_timeout at op %0d", i); break; end
            r = {1'b0, a2} - {1'b0, b2};
            if ({bo2, diff2} !== r) begin
                fails++; nerr++;
                $display("FAIL sweep2_result op %0d a=%h b=%h got %b_%h want %b_%h", i, a2, b2, bo2, diff2, r[2], r[1:0]);
            end
`ifdef SERIAL_SUB_OVF_EN
            tests++;
            if (ovf2 !== ((a2[1] != b2[1]) && (r[1] != a2[1]))) begin
                fails++; nerr++; $display("FAIL sweep2_ovf op %0d got %b", i, ovf2);
            end
`endif
            if (i > 0) begin
                tests++;
                if (cyc - last != 4) begin fails++; nerr++; $display("FAIL sweep2_spacing got %0d want 4", cyc - last); end
            end
            last = cyc;
            if (i == 999) start2 = 1'b0;
            else begin a2 = 2'($urandom); b2 = 2'($urandom); end
        end
        start2 = 1'b0;
        repeat (6) tick();
        $display("[TB] sweep WIDTH=2: 1000 ops, %0d errors", nerr);
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        test_ignore_start();
        test_reset_mid();
        test_sweep8();
        test_sweep2();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
